sequenciador_controle: RTL and testbench
========================================

// Module: sequenciador_controle
// PURPOSE
//  Multi-cycle microsequencer for the X/Y/Z register + ULA datapath; replaces the free-running step decoder.
//  Accepts one instruction per handshake, fetches operands over a valid/ready bus, drives Tx/Ty/Tz/Tula
//  cycle by cycle, then pulses done. Sits between the instruction source and the register/ULA datapath.
// PARAMETERS
//  CTRL_W  4  width of Tx/Ty/Tz/Tula codes (values zero-extended from 3-bit codes)
//  AMT_W   4  width of shift-amount field instr_arg
// PORTS
//  clk          in   1       rising-edge clock (only clock)
//  rst_n        in   1       asynchronous, active-low reset
//  instr_valid  in   1       instruction offered
//  instr_ready  out  1       1 only in IDLE; accept = instr_valid & instr_ready
//  instr_op     in   4       0..6 ULA ops ADD,SUB,MAIOR,MENOR,IGUAL,XOR,AND; 8 SHR; 9 SHL; 15 CLEAR; others illegal
//  instr_arg    in   AMT_W   shift count for SHR/SHL (ignored otherwise)
//  op_valid     in   1       operand present on external data bus
//  op_ready     out  1       1 in LOAD_A/LOAD_B; X loads on op_valid & op_ready
//  abort        in   1       synchronous cancel
//  Tx,Ty,Tz     out  CTRL_W  register ops: HOLD=0 LOAD=1 SHIFTR=2 SHIFTL=3 RESET=4
//  Tula         out  CTRL_W  ULA op code
//  done         out  1       1-cycle pulse, instruction finished
//  err          out  1       1-cycle pulse with done, illegal opcode
// BEHAVIOUR
//  Reset: state=IDLE, op/arg regs=0, counter=0. Outputs are combinational from state, latched op, op_valid:
//   in IDLE Tx=Ty=Tz=HOLD, Tula=ADD, done=err=op_ready=0, instr_ready=1. Default in every state: HOLD, ADD.
//  States/outputs/transitions (one per cycle unless waiting):
//   IDLE    accept -> latch op/arg; ULA/CLEAR -> CLR; SHR/SHL -> SHIFT (arg=0 -> DONE); illegal -> ERR
//   CLR     Tx=Ty=Tz=RESET; CLEAR -> DONE, else -> LOAD_A
//   LOAD_A  op_ready=1; op_valid: Tx=LOAD, -> XFER; else stay, all HOLD
//   XFER    Ty=LOAD (Y<=X) -> LOAD_B
//   LOAD_B  op_ready=1; op_valid: Tx=LOAD, -> EXEC; else stay
//   EXEC    Tz=LOAD, Tula=latched op -> DONE
//   SHIFT   Ty=SHIFTR (SHR) / SHIFTL (SHL); cnt counts 1..arg; on cnt==arg -> DONE (exactly arg shift cycles)
//   DONE    done=1 -> IDLE
//   ERR     done=1, err=1 -> IDLE; no register op issued for illegal opcodes
//  Latency ULA op with op_valid held high: accept + CLR,LOAD_A,XFER,LOAD_B,EXEC,DONE = done 6 cycles after accept edge.
//  Shift: done arg+1 cycles after accept; CLEAR: 2 cycles.
//  abort: in any non-IDLE state, that cycle outputs forced HOLD/ADD, op_ready=0, no done; next state IDLE.
//   abort in IDLE ignored. abort same cycle as op_valid in LOAD_x: abort wins, no LOAD.
//  instr_valid outside IDLE ignored (not latched); instr_op/arg sampled only at accept.
//  Shift counter AMT_W wide, arg=max value gives 2^AMT_W-1 shifts, no wrap.
//  Async reset mid-instruction: immediate return to IDLE values, no done.
// STRUCTURE
//  Package controle_pkg: register op codes (HOLD..RESET), ULA codes (ADD..AND), instr opcodes, state enum.
//  Sub-module controle_saida: pure combinational state+op+op_valid+abort -> Tx/Ty/Tz/Tula/op_ready/done/err.
//  Top holds state register, op/arg latches, shift counter.
// TESTING
//  Reset: rst_n=0 mid-LOAD_B -> outputs HOLD/ADD, instr_ready=1 immediately, no done.
//  SUB(1), op_valid=1 -> Tx/Ty/Tz: CLR(4,4,4), (1,0,0), (0,1,0), (1,0,0), (0,0,1) with Tula=1, done on 6th cycle.
//  AND(6), op_valid low 3 cycles in LOAD_A -> op_ready=1, Tx=HOLD 3 cycles, then sequence resumes; done once.
//  SHL arg=3 -> Ty=SHIFTL exactly 3 cycles, done next cycle; SHR arg=0 -> done 1 cycle after accept, no shift.
//  Illegal op 12 -> done=err=1 one cycle after accept, Tx=Ty=Tz=HOLD throughout.
//  abort in XFER -> that cycle Ty=HOLD, next cycle IDLE, no done; new instr_valid in DONE not accepted.

Source files
------------

// File: rtl/controle_pkg.sv
`default_nettype none
// ============================================================================
// Module : controle_pkg
// Brief  : Register op codes, ULA codes, opcodes and state encoding.
// Rev    : 1.0
// ============================================================================
package controle_pkg;

  localparam logic [2:0] c_reg_hold   = 3'd0;
  localparam logic [2:0] c_reg_load   = 3'd1;
  localparam logic [2:0] c_reg_shiftr = 3'd2;
  localparam logic [2:0] c_reg_shiftl = 3'd3;
  localparam logic [2:0] c_reg_reset  = 3'd4;

  localparam logic [2:0] c_ula_add   = 3'd0;
  localparam logic [2:0] c_ula_sub   = 3'd1;
  localparam logic [2:0] c_ula_maior = 3'd2;
  localparam logic [2:0] c_ula_menor = 3'd3;
  localparam logic [2:0] c_ula_igual = 3'd4;
  localparam logic [2:0] c_ula_xor   = 3'd5;
  localparam logic [2:0] c_ula_and   = 3'd6;

  localparam logic [3:0] c_op_shr   = 4'd8;
  localparam logic [3:0] c_op_shl   = 4'd9;
  localparam logic [3:0] c_op_clear = 4'd15;

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_CLR    = 4'd1,
    S_LOAD_A = 4'd2,
    S_XFER   = 4'd3,
    S_LOAD_B = 4'd4,
    S_EXEC   = 4'd5,
    S_SHIFT  = 4'd6,
    S_DONE   = 4'd7,
    S_ERR    = 4'd8
  } state_t;

  function automatic logic is_ula_op(input logic [3:0] op);
    return op <= {1'b0, c_ula_and};
  endfunction

endpackage
`default_nettype wire

// File: rtl/controle_saida.sv
`default_nettype none
// ============================================================================
// Module : controle_saida
// Brief  : Combinational decode of state/op/op_valid/abort into datapath controls.
// Rev    : 1.0
// ============================================================================
module controle_saida
  import controle_pkg::*;
#(
  parameter int CTRL_W = 4
) (
  input  state_t            state,
  input  logic [3:0]        op,
  input  logic              op_valid,
  input  logic              abort,
  output logic [CTRL_W-1:0] Tx,
  output logic [CTRL_W-1:0] Ty,
  output logic [CTRL_W-1:0] Tz,
  output logic [CTRL_W-1:0] Tula,
  output logic              op_ready,
  output logic              done,
  output logic              err
);

  function automatic logic [CTRL_W-1:0] ext(input logic [2:0] code);
    return CTRL_W'(code);
  endfunction

  always_comb begin
    Tx       = ext(c_reg_hold);
    Ty       = ext(c_reg_hold);
    Tz       = ext(c_reg_hold);
    Tula     = ext(c_ula_add);
    op_ready = 1'b0;
    done     = 1'b0;
    err      = 1'b0;
    // An abort cycle issues nothing, including the operand handshake.
    if (!abort) begin
      case (state)
        S_CLR: begin
          Tx = ext(c_reg_reset);
          Ty = ext(c_reg_reset);
          Tz = ext(c_reg_reset);
        end
        S_LOAD_A, S_LOAD_B: begin
          op_ready = 1'b1;
          if (op_valid) Tx = ext(c_reg_load);
        end
        S_XFER: Ty = ext(c_reg_load);
        S_EXEC: begin
          Tz   = ext(c_reg_load);
          Tula = ext(op[2:0]);
        end
        S_SHIFT: Ty = (op == c_op_shr) ? ext(c_reg_shiftr) : ext(c_reg_shiftl);
        S_DONE:  done = 1'b1;
        S_ERR: begin
          done = 1'b1;
          err  = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/sequenciador_controle.sv
`default_nettype none
// ============================================================================
// Module : sequenciador_controle
// Brief  : Multi-cycle microsequencer driving the X/Y/Z + ULA datapath.
// Rev    : 1.0
// ============================================================================
module sequenciador_controle
  import controle_pkg::*;
#(
  parameter int CTRL_W = 4,
  parameter int AMT_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [3:0]        instr_op,
  input  logic [AMT_W-1:0]  instr_arg,
  input  logic              op_valid,
  output logic              op_ready,
  input  logic              abort,
  output logic [CTRL_W-1:0] Tx,
  output logic [CTRL_W-1:0] Ty,
  output logic [CTRL_W-1:0] Tz,
  output logic [CTRL_W-1:0] Tula,
  output logic              done,
  output logic              err
);

  state_t           r_state;
  logic [3:0]       r_op;
  logic [AMT_W-1:0] r_arg;
  logic [AMT_W-1:0] r_cnt;
  logic             w_accept;

  assign instr_ready = (r_state == S_IDLE);
  assign w_accept    = instr_valid && instr_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_op    <= '0;
      r_arg   <= '0;
      r_cnt   <= '0;
    end else if (abort && (r_state != S_IDLE)) begin
      r_state <= S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_op  <= instr_op;
            r_arg <= instr_arg;
            // Counter starts at 1 so cnt==arg marks the last of arg shift cycles.
            r_cnt <= AMT_W'(1);
            if (is_ula_op(instr_op) || (instr_op == c_op_clear))
              r_state <= S_CLR;
            else if ((instr_op == c_op_shr) || (instr_op == c_op_shl))
              r_state <= (instr_arg == '0) ? S_DONE : S_SHIFT;
            else
              r_state <= S_ERR;
          end
        end
        S_CLR:    r_state <= (r_op == c_op_clear) ? S_DONE : S_LOAD_A;
        S_LOAD_A: if (op_valid) r_state <= S_XFER;
        S_XFER:   r_state <= S_LOAD_B;
        S_LOAD_B: if (op_valid) r_state <= S_EXEC;
        S_EXEC:   r_state <= S_DONE;
        S_SHIFT: begin
          if (r_cnt == r_arg) r_state <= S_DONE;
          else                r_cnt   <= r_cnt + AMT_W'(1);
        end
        S_DONE:   r_state <= S_IDLE;
        S_ERR:    r_state <= S_IDLE;
        default:  r_state <= S_IDLE;
      endcase
    end
  end

  controle_saida #(
    .CTRL_W (CTRL_W)
  ) u_saida (
    .state    (r_state),
    .op       (r_op),
    .op_valid (op_valid),
    .abort    (abort),
    .Tx       (Tx),
    .Ty       (Ty),
    .Tz       (Tz),
    .Tula     (Tula),
    .op_ready (op_ready),
    .done     (done),
    .err      (err)
  );

endmodule
`default_nettype wire

// File: tb/tb_sequenciador_controle.sv
`default_nettype none
// ============================================================================
// Module : tb_sequenciador_controle
// Brief  : Self-checking bench: vector table plus hand-written corner sequences.
// Rev    : 1.0
// ============================================================================
module tb_sequenciador_controle;

  localparam int CTRL_W = 4;
  localparam int AMT_W  = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             instr_valid = 1'b0;
  logic [3:0]       instr_op = '0;
  logic [AMT_W-1:0] instr_arg = '0;
  logic             op_valid = 1'b0;
  logic             abort = 1'b0;
  logic             instr_ready, op_ready, done, err;
  logic [CTRL_W-1:0] tx, ty, tz, tula;

  typedef struct packed {
    logic [3:0] tx, ty, tz, tula;
    logic opr, done, err, irdy;
  } obs_t;

  typedef struct {
    logic [3:0] op;
    logic [3:0] arg;
    int         lat;
    bit         err;
  } vec_t;

  obs_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  vec_t vecs[14];

  sequenciador_controle #(.CTRL_W(CTRL_W), .AMT_W(AMT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_op(instr_op), .instr_arg(instr_arg),
    .op_valid(op_valid), .op_ready(op_ready), .abort(abort),
    .Tx(tx), .Ty(ty), .Tz(tz), .Tula(tula),
    .done(done), .err(err)
  );

  always #5 clk = ~clk;

  function automatic obs_t mk(input logic [3:0] x, y, z, u,
                              input logic opr, d, e, irdy);
    obs_t o;
    o.tx = x; o.ty = y; o.tz = z; o.tula = u;
    o.opr = opr; o.done = d; o.err = e; o.irdy = irdy;
    return o;
  endfunction

  function automatic obs_t idle_obs();
    return mk(0, 0, 0, 0, 0, 0, 0, 1);
  endfunction

  // Expected outputs k cycles after accept, op_valid held high, no abort.
  function automatic obs_t model(input logic [3:0] op, input int k, input int lat, input bit e);
    obs_t o;
    o = mk(0, 0, 0, 0, 0, 0, 0, 0);
    if (k == lat) begin
      o.done = 1'b1;
      o.err  = e;
    end else if (op <= 4'd6) begin
      case (k)
        1:    begin o.tx = 4; o.ty = 4; o.tz = 4; end
        2, 4: begin o.tx = 1; o.opr = 1'b1; end
        3:    o.ty = 1;
        5:    begin o.tz = 1; o.tula = op; end
        default: ;
      endcase
    end else if (op == 4'd15) begin
      o.tx = 4; o.ty = 4; o.tz = 4;
    end else if (op == 4'd8) begin
      o.ty = 2;
    end else if (op == 4'd9) begin
      o.ty = 3;
    end
    return o;
  endfunction

  task automatic compare(input string name);
    obs_t e, a;
    e = sb_q.pop_front();
    a = {tx, ty, tz, tula, op_ready, done, err, instr_ready};
    n_checks++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got {Tx,Ty,Tz,Tula,opr,done,err,irdy}=%h expected %h @%0t", name, a, e, $time);
    end
  endtask

  task automatic step(input string name, input obs_t e);
    sb_q.push_back(e);
    @(negedge clk);
    compare(name);
    @(posedge clk);
    #1;
  endtask

  task automatic accept(input logic [3:0] op, input logic [3:0] arg);
    instr_valid = 1'b1;
    instr_op    = op;
    instr_arg   = arg;
    step("accept", idle_obs());
    instr_valid = 1'b0;
    instr_op    = 4'd3;
    instr_arg   = 4'd7;
  endtask

  initial begin
    vecs[0]  = '{4'd0,  4'd0,  6,  1'b0};
    vecs[1]  = '{4'd1,  4'd5,  6,  1'b0};
    vecs[2]  = '{4'd2,  4'd0,  6,  1'b0};
    vecs[3]  = '{4'd3,  4'd0,  6,  1'b0};
    vecs[4]  = '{4'd4,  4'd0,  6,  1'b0};
    vecs[5]  = '{4'd5,  4'd0,  6,  1'b0};
    vecs[6]  = '{4'd6,  4'd0,  6,  1'b0};
    vecs[7]  = '{4'd8,  4'd0,  1,  1'b0};
    vecs[8]  = '{4'd9,  4'd3,  4,  1'b0};
    vecs[9]  = '{4'd8,  4'd15, 16, 1'b0};
    vecs[10] = '{4'd15, 4'd0,  2,  1'b0};
    vecs[11] = '{4'd12, 4'd0,  1,  1'b1};
    vecs[12] = '{4'd7,  4'd3,  1,  1'b1};
    vecs[13] = '{4'd11, 4'd2,  1,  1'b1};

    step("reset_idle", idle_obs());
    rst_n = 1'b1;
    step("post_reset_idle", idle_obs());

    op_valid = 1'b1;
    for (int i = 0; i < 14; i++) begin
      accept(vecs[i].op, vecs[i].arg);
      for (int k = 1; k <= vecs[i].lat; k++)
        step($sformatf("vec%0d_op%0d_k%0d", i, vecs[i].op, k),
             model(vecs[i].op, k, vecs[i].lat, vecs[i].err));
      step($sformatf("vec%0d_back_idle", i), idle_obs());
    end

    // Operand stall in LOAD_A
    accept(4'd6, 4'd0);
    step("and_clr", mk(4, 4, 4, 0, 0, 0, 0, 0));
    op_valid = 1'b0;
    repeat (3) step("and_stall", mk(0, 0, 0, 0, 1, 0, 0, 0));
    op_valid = 1'b1;
    step("and_loada", mk(1, 0, 0, 0, 1, 0, 0, 0));
    step("and_xfer",  mk(0, 1, 0, 0, 0, 0, 0, 0));
    step("and_loadb", mk(1, 0, 0, 0, 1, 0, 0, 0));
    step("and_exec",  mk(0, 0, 1, 6, 0, 0, 0, 0));
    step("and_done",  mk(0, 0, 0, 0, 0, 1, 0, 0));
    step("and_idle",  idle_obs());

    // Abort in XFER
    accept(4'd0, 4'd0);
    step("abx_clr",   mk(4, 4, 4, 0, 0, 0, 0, 0));
    step("abx_loada", mk(1, 0, 0, 0, 1, 0, 0, 0));
    abort = 1'b1;
    step("abx_abort", mk(0, 0, 0, 0, 0, 0, 0, 0));
    abort = 1'b0;
    step("abx_idle",  idle_obs());
    step("abx_stay",  idle_obs());

    // Abort together with op_valid in LOAD_A
    accept(4'd1, 4'd0);
    step("aba_clr",   mk(4, 4, 4, 0, 0, 0, 0, 0));
    abort = 1'b1;
    step("aba_abort", mk(0, 0, 0, 0, 0, 0, 0, 0));
    abort = 1'b0;
    step("aba_idle",  idle_obs());

    // Abort in IDLE is ignored
    abort = 1'b1;
    accept(4'd15, 4'd0);
    abort = 1'b0;
    step("abi_clr",   mk(4, 4, 4, 0, 0, 0, 0, 0));
    step("abi_done",  mk(0, 0, 0, 0, 0, 1, 0, 0));
    step("abi_idle",  idle_obs());

    // instr_valid during DONE is not accepted
    accept(4'd15, 4'd0);
    step("dn_clr", mk(4, 4, 4, 0, 0, 0, 0, 0));
    instr_valid = 1'b1;
    instr_op    = 4'd1;
    step("dn_done", mk(0, 0, 0, 0, 0, 1, 0, 0));
    instr_valid = 1'b0;
    step("dn_idle1", idle_obs());
    step("dn_idle2", idle_obs());

    // Asynchronous reset while waiting in LOAD_B
    accept(4'd1, 4'd0);
    step("rs_clr",   mk(4, 4, 4, 0, 0, 0, 0, 0));
    step("rs_loada", mk(1, 0, 0, 0, 1, 0, 0, 0));
    step("rs_xfer",  mk(0, 1, 0, 0, 0, 0, 0, 0));
    op_valid = 1'b0;
    sb_q.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0));
    @(negedge clk);
    compare("rs_loadb_wait");
    #2 rst_n = 1'b0;
    #1;
    sb_q.push_back(idle_obs());
    compare("rs_async");
    @(posedge clk);
    #1;
    step("rs_held", idle_obs());
    rst_n    = 1'b1;
    op_valid = 1'b1;
    step("rs_released", idle_obs());

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got no end expected end");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
